can_decoder: RTL and testbench

- Bit-level CAN 2.0A/2.0B receive decoder.
- Sits behind the bit-timing logic. It consumes one sampled bus bit per sample_point, removes stuff bits, and checks CRC-15 and fixed-form bits.
- Exposes every decoded frame field as a registered output, and flags protocol errors to the error-management logic.

---
 rtl/can_decoder.sv | 273 +++++++++++++++++++++++++++
 tb/tb_can_decoder.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_decoder.sv
// rtl/can_decoder.sv - bit-level CAN 2.0A/2.0B receive decoder
// Destuffs sampled bus bits, decodes every frame field, checks CRC-15 and fixed-form bits.
module can_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_bit,
  input  logic        sample_point,
  input  logic        error_in,
  output logic        error_out,
  output logic        field_start_of_frame,
  output logic [10:0] field_id_a,
  output logic        field_ide,
  output logic        field_rtr,
  output logic        field_srr,
  output logic        field_reserved1,
  output logic        field_reserved0,
  output logic [17:0] field_id_b,
  output logic [3:0]  field_dlc,
  output logic [63:0] field_data,
  output logic [14:0] field_crc,
  output logic        field_crc_delimiter,
  output logic        field_ack_slot
);

  typedef enum logic [4:0] {
    S_IDLE, S_ID_A, S_BIT12, S_IDE, S_ID_B, S_RTR_EXT, S_R1, S_R0, S_DLC,
    S_DATA, S_CRC, S_CRC_DELIM, S_ACK_SLOT, S_ACK_DELIM, S_EOF,
    S_INTERMISSION, S_ERR_WAIT
  } state_t;

  state_t      state;
  logic [6:0]  bit_cnt;
  logic [14:0] crc_reg;
  logic        crc_err;
  logic [2:0]  stuff_cnt;
  logic        stuff_last;

  logic        stuff_active;
  logic        stuff_bit;
  logic        crc_active;
  logic [14:0] crc_next;
  logic [3:0]  dlc_next;
  logic [6:0]  data_last;
  logic [14:0] crc_rx;

  always_comb begin
    stuff_active = 1'b0;
    case (state)
      S_ID_A, S_BIT12, S_IDE, S_ID_B, S_RTR_EXT, S_R1, S_R0, S_DLC, S_DATA, S_CRC:
        stuff_active = 1'b1;
      default: stuff_active = 1'b0;
    endcase
    stuff_bit  = stuff_active && (stuff_cnt == 3'd5);
    // CRC covers SOF through the last data bit; the CRC field itself is excluded
    crc_active = stuff_active && (state != S_CRC);
    crc_next   = {crc_reg[13:0], 1'b0} ^ ((rx_bit ^ crc_reg[14]) ? 15'h4599 : 15'h0000);
    dlc_next   = {field_dlc[2:0], rx_bit};
    data_last  = (field_dlc[3] ? 7'd64 : {1'b0, field_dlc[2:0], 3'b000}) - 7'd1;
    crc_rx     = {field_crc[13:0], rx_bit};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      bit_cnt              <= 7'd0;
      crc_reg              <= 15'd0;
      crc_err              <= 1'b0;
      stuff_cnt            <= 3'd0;
      stuff_last           <= 1'b0;
      error_out            <= 1'b0;
      field_start_of_frame <= 1'b0;
      field_id_a           <= 11'd0;
      field_ide            <= 1'b0;
      field_rtr            <= 1'b0;
      field_srr            <= 1'b0;
      field_reserved1      <= 1'b0;
      field_reserved0      <= 1'b0;
      field_id_b           <= 18'd0;
      field_dlc            <= 4'd0;
      field_data           <= 64'd0;
      field_crc            <= 15'd0;
      field_crc_delimiter  <= 1'b0;
      field_ack_slot       <= 1'b0;
    end else begin
      error_out <= 1'b0;
      if (error_in && (state != S_IDLE)) begin
        state   <= S_ERR_WAIT;
        bit_cnt <= 7'd0;
      end else if (sample_point) begin
        if (stuff_bit) begin
          if (rx_bit == stuff_last) begin
            error_out <= 1'b1;
            state     <= S_ERR_WAIT;
            bit_cnt   <= 7'd0;
          end else begin
            stuff_cnt  <= 3'd1;
            stuff_last <= rx_bit;
          end
        end else begin
          if (stuff_active) begin
            if (rx_bit == stuff_last) begin
              stuff_cnt <= stuff_cnt + 3'd1;
            end else begin
              stuff_cnt  <= 3'd1;
              stuff_last <= rx_bit;
            end
          end
          if (crc_active) begin
            crc_reg <= crc_next;
          end

          case (state)
            S_IDLE, S_INTERMISSION: begin
              if (!rx_bit) begin
                // SOF: CRC seed is 0 and a dominant bit leaves it at 0
                state                <= S_ID_A;
                bit_cnt              <= 7'd0;
                crc_reg              <= 15'd0;
                crc_err              <= 1'b0;
                stuff_cnt            <= 3'd1;
                stuff_last           <= 1'b0;
                field_start_of_frame <= 1'b0;
                field_id_a           <= 11'd0;
                field_ide            <= 1'b0;
                field_rtr            <= 1'b0;
                field_srr            <= 1'b0;
                field_reserved1      <= 1'b0;
                field_reserved0      <= 1'b0;
                field_id_b           <= 18'd0;
                field_dlc            <= 4'd0;
                field_data           <= 64'd0;
                field_crc            <= 15'd0;
                field_crc_delimiter  <= 1'b0;
                field_ack_slot       <= 1'b0;
              end else if (state == S_INTERMISSION) begin
                if (bit_cnt == 7'd1) begin
                  state   <= S_IDLE;
                  bit_cnt <= 7'd0;
                end else begin
                  bit_cnt <= bit_cnt + 7'd1;
                end
              end
            end
            S_ID_A: begin
              field_id_a <= {field_id_a[9:0], rx_bit};
              if (bit_cnt == 7'd10) begin
                state   <= S_BIT12;
                bit_cnt <= 7'd0;
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
              end
            end
            S_BIT12: begin
              field_rtr <= rx_bit;
              state     <= S_IDE;
            end
            S_IDE: begin
              field_ide <= rx_bit;
              if (rx_bit) begin
                field_srr <= field_rtr;
                field_rtr <= 1'b0;
                state     <= S_ID_B;
                bit_cnt   <= 7'd0;
              end else begin
                state <= S_R0;
              end
            end
            S_ID_B: begin
              field_id_b <= {field_id_b[16:0], rx_bit};
              if (bit_cnt == 7'd17) begin
                state   <= S_RTR_EXT;
                bit_cnt <= 7'd0;
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
              end
            end
            S_RTR_EXT: begin
              field_rtr <= rx_bit;
              state     <= S_R1;
            end
            S_R1: begin
              field_reserved1 <= rx_bit;
              state           <= S_R0;
            end
            S_R0: begin
              field_reserved0 <= rx_bit;
              state           <= S_DLC;
              bit_cnt         <= 7'd0;
            end
            S_DLC: begin
              field_dlc <= dlc_next;
              if (bit_cnt == 7'd3) begin
                bit_cnt <= 7'd0;
                state   <= (field_rtr || (dlc_next == 4'd0)) ? S_CRC : S_DATA;
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
              end
            end
            S_DATA: begin
              field_data <= {field_data[62:0], rx_bit};
              if (bit_cnt == data_last) begin
                state   <= S_CRC;
                bit_cnt <= 7'd0;
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
              end
            end
            S_CRC: begin
              field_crc <= crc_rx;
              if (bit_cnt == 7'd14) begin
                crc_err <= (crc_rx != crc_reg);
                state   <= S_CRC_DELIM;
                bit_cnt <= 7'd0;
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
              end
            end
            S_CRC_DELIM: begin
              field_crc_delimiter <= rx_bit;
              if (!rx_bit) begin
                error_out <= 1'b1;
                state     <= S_ERR_WAIT;
              end else begin
                state <= S_ACK_SLOT;
              end
            end
            S_ACK_SLOT: begin
              field_ack_slot <= rx_bit;
              state          <= S_ACK_DELIM;
            end
            S_ACK_DELIM: begin
              // CRC mismatch is reported only once the delimiter itself is well formed
              if (!rx_bit || crc_err) begin
                error_out <= 1'b1;
                state     <= S_ERR_WAIT;
              end else begin
                state <= S_EOF;
              end
              bit_cnt <= 7'd0;
            end
            S_EOF: begin
              if (!rx_bit) begin
                error_out <= 1'b1;
                state     <= S_ERR_WAIT;
                bit_cnt   <= 7'd0;
              end else if (bit_cnt == 7'd6) begin
                state   <= S_INTERMISSION;
                bit_cnt <= 7'd0;
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
              end
            end
            S_ERR_WAIT: begin
              if (!rx_bit) begin
                bit_cnt <= 7'd0;
              end else if (bit_cnt == 7'd10) begin
                state   <= S_IDLE;
                bit_cnt <= 7'd0;
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
              end
            end
            default: begin
              state   <= S_IDLE;
              bit_cnt <= 7'd0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_can_decoder.sv
// tb/tb_can_decoder.sv - randomized self-checking bench for can_decoder
// Frames are built from field values, CRC by polynomial division, then bit-stuffed.
module tb_can_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_bit;
  logic        sample_point;
  logic        error_in;
  logic        error_out;
  logic        field_start_of_frame;
  logic [10:0] field_id_a;
  logic        field_ide;
  logic        field_rtr;
  logic        field_srr;
  logic        field_reserved1;
  logic        field_reserved0;
  logic [17:0] field_id_b;
  logic [3:0]  field_dlc;
  logic [63:0] field_data;
  logic [14:0] field_crc;
  logic        field_crc_delimiter;
  logic        field_ack_slot;

  can_decoder dut (
    .clock(clock), .reset(reset), .rx_bit(rx_bit), .sample_point(sample_point),
    .error_in(error_in), .error_out(error_out),
    .field_start_of_frame(field_start_of_frame), .field_id_a(field_id_a),
    .field_ide(field_ide), .field_rtr(field_rtr), .field_srr(field_srr),
    .field_reserved1(field_reserved1), .field_reserved0(field_reserved0),
    .field_id_b(field_id_b), .field_dlc(field_dlc), .field_data(field_data),
    .field_crc(field_crc), .field_crc_delimiter(field_crc_delimiter),
    .field_ack_slot(field_ack_slot)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;

  // error_out high-cycles, sampled just after each active edge
  always @(posedge clock) begin
    #1;
    if (error_out === 1'b1) err_pulses++;
  end

  bit          frame_q[$];
  bit          stuff_q[$];
  int          crc_delim_idx;
  int          ack_delim_idx;
  int          data_pos;
  logic [10:0] g_ida;
  logic [17:0] g_idb;
  bit          g_ide, g_srr, g_rtr, g_r1, g_r0;
  logic [3:0]  g_dlc;
  logic [63:0] g_data_exp;
  logic [14:0] g_crc;

  // remainder of M(x)*x^15 divided by x^15+x^14+x^10+x^8+x^7+x^4+x^3+1
  function automatic logic [14:0] crc15(input bit m[$]);
    logic [15:0] rem;
    int n;
    rem = 16'd0;
    n = m.size();
    for (int i = 0; i < n + 15; i++) begin
      rem = {rem[14:0], (i < n) ? m[i] : 1'b0};
      if (rem[15]) rem = rem ^ 16'hC599;
    end
    return rem[14:0];
  endfunction

  function automatic logic [119:0] dut_vec();
    return {field_start_of_frame, field_id_a, field_ide, field_rtr, field_srr,
            field_reserved1, field_reserved0, field_id_b, field_dlc, field_data,
            field_crc, field_crc_delimiter, field_ack_slot};
  endfunction

  function automatic logic [119:0] exp_vec(input logic [63:0] data, input logic [14:0] crc,
                                           input bit delim, input bit ack);
    return {1'b0, g_ida, g_ide, g_rtr, g_ide ? g_srr : 1'b0, g_ide ? g_r1 : 1'b0, g_r0,
            g_ide ? g_idb : 18'd0, g_dlc, data, crc, delim, ack};
  endfunction

  task automatic build_frame(input logic [10:0] ida, input bit ide, input bit srr,
                             input logic [17:0] idb, input bit rtr, input bit r1, input bit r0,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input bit bad_crc, input logic [14:0] bad_val);
    bit raw[$];
    int nbytes;
    int run;
    bit last;
    raw = {};
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(ida[i]);
    if (!ide) begin
      raw.push_back(rtr); raw.push_back(1'b0); raw.push_back(r0);
    end else begin
      raw.push_back(srr); raw.push_back(1'b1);
      for (int i = 17; i >= 0; i--) raw.push_back(idb[i]);
      raw.push_back(rtr); raw.push_back(r1); raw.push_back(r0);
    end
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    data_pos = raw.size();
    nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    g_data_exp = 64'd0;
    for (int i = nbytes * 8 - 1; i >= 0; i--) begin
      raw.push_back(data[i]);
      g_data_exp = {g_data_exp[62:0], data[i]};
    end
    g_crc = bad_crc ? bad_val : crc15(raw);
    for (int i = 14; i >= 0; i--) raw.push_back(g_crc[i]);
    g_ida = ida; g_ide = ide; g_srr = srr; g_idb = idb; g_rtr = rtr;
    g_r1 = r1; g_r0 = r0; g_dlc = dlc;
    frame_q = {}; stuff_q = {};
    run = 0; last = 1'b0;
    for (int k = 0; k < raw.size(); k++) begin
      if (run == 5) begin
        frame_q.push_back(!last); stuff_q.push_back(1'b1);
        last = !last; run = 1;
      end
      frame_q.push_back(raw[k]); stuff_q.push_back(1'b0);
      if (k == 0 || raw[k] != last) begin run = 1; last = raw[k]; end
      else run++;
    end
    crc_delim_idx = frame_q.size();
    frame_q.push_back(1'b1); stuff_q.push_back(1'b0);
    frame_q.push_back(1'b0); stuff_q.push_back(1'b0);
    ack_delim_idx = frame_q.size();
    for (int i = 0; i < 10; i++) begin
      frame_q.push_back(1'b1); stuff_q.push_back(1'b0);
    end
  endtask

  task automatic send_bit(input bit b, input int gap);
    for (int g = 0; g < gap; g++) begin
      rx_bit = 1'($urandom);
      sample_point = 1'b0;
      @(negedge clock);
    end
    rx_bit = b;
    sample_point = 1'b1;
    @(negedge clock);
    sample_point = 1'b0;
    rx_bit = 1'b1;
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < frame_q.size(); i++) send_bit(frame_q[i], gap);
  endtask

  task automatic idle_bits();
    for (int i = 0; i < 12; i++) send_bit(1'b1, 0);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({error_out, dut_vec()} !== 121'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", {error_out, dut_vec()});
    end
  endtask

  task automatic test_base_frame();
    int e0;
    idle_bits();
    build_frame(11'h123, 1'b0, 1'b0, 18'd0, 1'b0, 1'b0, 1'b0, 4'd1, 64'hA5, 1'b0, 15'd0);
    e0 = err_pulses;
    send_frame(0);
    n_cmp++;
    if (dut_vec() !== exp_vec(g_data_exp, g_crc, 1'b1, 1'b0)) begin
      n_bad++; $display("FAIL base_fields: got %h want %h", dut_vec(), exp_vec(g_data_exp, g_crc, 1'b1, 1'b0));
    end
    n_cmp++;
    if (field_data !== 64'hA5 || field_id_a !== 11'h123) begin
      n_bad++; $display("FAIL base_data_id: got %h/%h want a5/123", field_data, field_id_a);
    end
    n_cmp++;
    if (err_pulses - e0 !== 0) begin
      n_bad++; $display("FAIL base_no_error: got %0d pulses want 0", err_pulses - e0);
    end
  endtask

  task automatic test_stuffing();
    int e0;
    int nstuff;
    idle_bits();
    build_frame(11'h000, 1'b0, 1'b0, 18'd0, 1'b0, 1'b0, 1'b0, 4'd1, 64'hFF, 1'b0, 15'd0);
    nstuff = 0;
    foreach (stuff_q[i]) if (stuff_q[i]) nstuff++;
    e0 = err_pulses;
    send_frame(0);
    n_cmp++;
    if (dut_vec() !== exp_vec(64'hFF, g_crc, 1'b1, 1'b0) || nstuff < 3) begin
      n_bad++; $display("FAIL stuffed_fields: got %h want %h (stuff bits %0d)", dut_vec(), exp_vec(64'hFF, g_crc, 1'b1, 1'b0), nstuff);
    end
    n_cmp++;
    if (err_pulses - e0 !== 0) begin
      n_bad++; $display("FAIL stuffed_no_error: got %0d pulses want 0", err_pulses - e0);
    end
  endtask

  task automatic test_bad_crc();
    int e0;
    idle_bits();
    build_frame(11'h000, 1'b0, 1'b0, 18'd0, 1'b0, 1'b0, 1'b0, 4'd1, 64'hFF, 1'b1, 15'h3FFF);
    e0 = err_pulses;
    for (int i = 0; i < ack_delim_idx; i++) send_bit(frame_q[i], 0);
    n_cmp++;
    if (err_pulses - e0 !== 0) begin
      n_bad++; $display("FAIL bad_crc_early: got %0d pulses want 0 before ack delimiter", err_pulses - e0);
    end
    send_bit(frame_q[ack_delim_idx], 0);
    n_cmp++;
    if (err_pulses - e0 !== 1) begin
      n_bad++; $display("FAIL bad_crc_pulse: got %0d pulses want 1", err_pulses - e0);
    end
    for (int i = ack_delim_idx + 1; i < frame_q.size(); i++) send_bit(frame_q[i], 0);
    n_cmp++;
    if (field_crc !== 15'h3FFF || err_pulses - e0 !== 1) begin
      n_bad++; $display("FAIL bad_crc_field: got crc %h pulses %0d want 3fff/1", field_crc, err_pulses - e0);
    end
  endtask

  task automatic test_extended_rtr();
    int e0;
    idle_bits();
    build_frame(11'h555, 1'b1, 1'b1, 18'h2AAAA, 1'b1, 1'b0, 1'b0, 4'd4, 64'h1122334455667788, 1'b0, 15'd0);
    e0 = err_pulses;
    send_frame(0);
    n_cmp++;
    if (dut_vec() !== exp_vec(64'd0, g_crc, 1'b1, 1'b0) || field_id_b !== 18'h2AAAA) begin
      n_bad++; $display("FAIL ext_rtr_fields: got %h want %h", dut_vec(), exp_vec(64'd0, g_crc, 1'b1, 1'b0));
    end
    n_cmp++;
    if (err_pulses - e0 !== 0) begin
      n_bad++; $display("FAIL ext_rtr_no_error: got %0d pulses want 0", err_pulses - e0);
    end
  endtask

  task automatic test_stuff_error();
    int e0;
    idle_bits();
    e0 = err_pulses;
    for (int i = 0; i < 6; i++) send_bit(1'b0, 0);
    n_cmp++;
    if (err_pulses - e0 !== 1) begin
      n_bad++; $display("FAIL stuff_err_pulse: got %0d pulses want 1", err_pulses - e0);
    end
    for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
    build_frame(11'h123, 1'b0, 1'b0, 18'd0, 1'b0, 1'b0, 1'b0, 4'd1, 64'hA5, 1'b0, 15'd0);
    for (int i = 0; i < 12; i++) send_bit(frame_q[i], 0);
    n_cmp++;
    if (field_id_a !== 11'h000) begin
      n_bad++; $display("FAIL stuff_err_wait: got id_a %h want 000 (SOF taken too early)", field_id_a);
    end
    for (int i = 0; i < 11; i++) send_bit(1'b1, 0);
    send_frame(0);
    n_cmp++;
    if (dut_vec() !== exp_vec(g_data_exp, g_crc, 1'b1, 1'b0) || err_pulses - e0 !== 1) begin
      n_bad++; $display("FAIL stuff_err_recover: got %h pulses %0d want %h/1", dut_vec(), err_pulses - e0, exp_vec(g_data_exp, g_crc, 1'b1, 1'b0));
    end
  endtask

  task automatic test_crc_delim_form();
    int e0;
    idle_bits();
    build_frame(11'h6B1, 1'b0, 1'b0, 18'd0, 1'b0, 1'b0, 1'b0, 4'd2, 64'h3C96, 1'b0, 15'd0);
    frame_q[crc_delim_idx] = 1'b0;
    e0 = err_pulses;
    for (int i = 0; i < crc_delim_idx; i++) send_bit(frame_q[i], 0);
    n_cmp++;
    if (err_pulses - e0 !== 0) begin
      n_bad++; $display("FAIL form_early: got %0d pulses want 0", err_pulses - e0);
    end
    send_bit(frame_q[crc_delim_idx], 0);
    n_cmp++;
    if (err_pulses - e0 !== 1) begin
      n_bad++; $display("FAIL form_pulse: got %0d pulses want 1", err_pulses - e0);
    end
    for (int i = crc_delim_idx + 1; i < frame_q.size(); i++) send_bit(frame_q[i], 0);
    n_cmp++;
    if (dut_vec() !== exp_vec(g_data_exp, g_crc, 1'b0, 1'b0)) begin
      n_bad++; $display("FAIL form_fields: got %h want %h", dut_vec(), exp_vec(g_data_exp, g_crc, 1'b0, 1'b0));
    end
  endtask

  task automatic test_error_in();
    int e0;
    int consumed;
    int j;
    idle_bits();
    error_in = 1'b1;
    @(negedge clock);
    error_in = 1'b0;
    build_frame(11'h2F0, 1'b0, 1'b0, 18'd0, 1'b0, 1'b0, 1'b0, 4'd8, 64'h0123456789ABCDEF, 1'b0, 15'd0);
    e0 = err_pulses;
    consumed = 0;
    j = 0;
    while (consumed < data_pos + 20) begin
      send_bit(frame_q[j], 0);
      if (!stuff_q[j]) consumed++;
      j++;
    end
    error_in = 1'b1;
    @(negedge clock);
    error_in = 1'b0;
    n_cmp++;
    if (err_pulses - e0 !== 0) begin
      n_bad++; $display("FAIL abort_no_pulse: got %0d pulses want 0", err_pulses - e0);
    end
    while (j < frame_q.size()) begin
      send_bit(frame_q[j], 0);
      j++;
    end
    n_cmp++;
    if (dut_vec() !== exp_vec(64'h0123456789ABCDEF >> 44, 15'd0, 1'b0, 1'b0) || err_pulses - e0 !== 0) begin
      n_bad++; $display("FAIL abort_partial: got %h pulses %0d want %h/0", dut_vec(), err_pulses - e0, exp_vec(64'h0123456789ABCDEF >> 44, 15'd0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_sample_gap();
    int e0;
    idle_bits();
    build_frame(11'h3A5, 1'b1, 1'b1, 18'h1F0F3, 1'b0, 1'b1, 1'b0, 4'd3, 64'hC0FFEE, 1'b0, 15'd0);
    e0 = err_pulses;
    send_frame(3);
    n_cmp++;
    if (dut_vec() !== exp_vec(g_data_exp, g_crc, 1'b1, 1'b0) || err_pulses - e0 !== 0) begin
      n_bad++; $display("FAIL gap_fields: got %h pulses %0d want %h/0", dut_vec(), err_pulses - e0, exp_vec(g_data_exp, g_crc, 1'b1, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    int n;
    idle_bits();
    build_frame(11'h7F0, 1'b0, 1'b0, 18'd0, 1'b0, 1'b0, 1'b1, 4'd2, 64'hBEEF, 1'b0, 15'd0);
    n = frame_q.size();
    e0 = err_pulses;
    for (int i = 0; i < n - 1; i++) send_bit(frame_q[i], 0);
    build_frame(11'h0F1, 1'b1, 1'b0, 18'h00A5A, 1'b0, 1'b0, 1'b0, 4'd9, 64'hFEDCBA9876543210, 1'b0, 15'd0);
    send_frame(0);
    n_cmp++;
    if (dut_vec() !== exp_vec(g_data_exp, g_crc, 1'b1, 1'b0) || err_pulses - e0 !== 0) begin
      n_bad++; $display("FAIL b2b_fields: got %h pulses %0d want %h/0", dut_vec(), err_pulses - e0, exp_vec(g_data_exp, g_crc, 1'b1, 1'b0));
    end
  endtask

  task automatic test_random();
    int e0;
    for (int t = 0; t < 16; t++) begin
      idle_bits();
      build_frame(11'($urandom), 1'($urandom), 1'($urandom), 18'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom), 1'($urandom), 4'($urandom), {32'($urandom), 32'($urandom)}, 1'b0, 15'd0);
      e0 = err_pulses;
      send_frame(int'($urandom_range(0, 2)));
      n_cmp++;
      if (dut_vec() !== exp_vec(g_data_exp, g_crc, 1'b1, 1'b0) || err_pulses - e0 !== 0) begin
        n_bad++; $display("FAIL random_%0d: got %h pulses %0d want %h/0", t, dut_vec(), err_pulses - e0, exp_vec(g_data_exp, g_crc, 1'b1, 1'b0));
      end
    end
  endtask

  task automatic test_reset_mid_data();
    int consumed;
    int j;
    idle_bits();
    build_frame(11'h456, 1'b0, 1'b0, 18'd0, 1'b0, 1'b0, 1'b0, 4'd4, 64'h89ABCDEF, 1'b0, 15'd0);
    consumed = 0;
    j = 0;
    while (consumed < data_pos + 6) begin
      send_bit(frame_q[j], 0);
      if (!stuff_q[j]) consumed++;
      j++;
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({error_out, dut_vec()} !== 121'd0) begin
      n_bad++; $display("FAIL reset_mid_data: got %h want 0", {error_out, dut_vec()});
    end
    @(negedge clock);
    reset = 1'b0;
    send_frame(0);
    n_cmp++;
    if (dut_vec() !== exp_vec(g_data_exp, g_crc, 1'b1, 1'b0)) begin
      n_bad++; $display("FAIL reset_then_frame: got %h want %h", dut_vec(), exp_vec(g_data_exp, g_crc, 1'b1, 1'b0));
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_bit = 1'b1;
    sample_point = 1'b0;
    error_in = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_base_frame();
    test_back_to_back();
    test_stuffing();
    test_bad_crc();
    test_extended_rtr();
    test_stuff_error();
    test_crc_delim_form();
    test_error_in();
    test_sample_gap();
    test_random();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
